// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: branch funct3 encodings, BHT counter
// states and the front-end flush FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    typedef enum logic {
        FL_IDLE   = 1'b0,
        FL_ACTIVE = 1'b1
    } flush_state_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
        bht_state_t n;
        n = s;
        if (taken) begin
            if (s != ST) begin
                n = bht_state_t'(s + 2'd1);
            end
        end else begin
            if (s != SNT) begin
                n = bht_state_t'(s - 2'd1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV32I branch condition evaluator; o_valid flags the
// reserved funct3 encodings 010/011 as non-branches.
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic            o_valid
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_taken = 1'b0;
        o_valid = 1'b1;
        case (i_funct3)
            F3_BEQ:  o_taken = w_eq;
            F3_BNE:  o_taken = ~w_eq;
            F3_BLT:  o_taken = w_lt;
            F3_BGE:  o_taken = ~w_lt;
            F3_BLTU: o_taken = w_ltu;
            F3_BGEU: o_taken = ~w_ltu;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution and prediction: BHT of 2-bit counters read from IF,
// resolution in EX with a registered redirect and a multi-cycle IF/ID flush.
module branch_resolve
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDX = $clog2(BHT_DEPTH);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    bht_state_t          r_bht [BHT_DEPTH];
    bht_state_t          w_if_entry;
    bht_state_t          w_ex_entry;
    logic [IDX-1:0]      w_if_idx;
    logic [IDX-1:0]      w_ex_idx;

    logic                w_cmp_taken;
    logic                w_cmp_valid;
    logic                w_is_branch;
    logic                w_accept;
    logic                w_bht_we;
    logic                w_mispredict;
    logic                w_redirect_nxt;
    logic [XLEN-1:0]     w_pc_imm;
    logic [XLEN-1:0]     w_pc_seq;
    logic [XLEN-1:0]     w_jalr_tgt;
    logic [XLEN-1:0]     w_target;

    logic                r_redirect;
    logic [XLEN-1:0]     r_redirect_pc;
    logic [31:0]         r_branch_cnt;
    logic [31:0]         r_mispredict_cnt;

    flush_state_t        r_flush_state;
    flush_state_t        w_flush_state_nxt;
    logic [FCW-1:0]      r_flush_cnt;
    logic [FCW-1:0]      w_flush_cnt_nxt;

    logic                w_unused;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .i_funct3 (ex_funct3),
        .i_rs1    (ex_rs1),
        .i_rs2    (ex_rs2),
        .o_taken  (w_cmp_taken),
        .o_valid  (w_cmp_valid)
    );

    assign w_if_idx      = if_pc[IDX+1:2];
    assign w_ex_idx      = ex_pc[IDX+1:2];
    assign w_if_entry    = r_bht[w_if_idx];
    assign w_ex_entry    = r_bht[w_ex_idx];
    assign if_pred_taken = w_if_entry[1];
    assign w_unused      = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

    // JAL carries immediate bits in funct3, so validity only gates conditional branches.
    assign w_is_branch    = ex_branch & ~ex_jump;
    assign w_accept       = ex_valid & ~flush & (ex_jump | (w_is_branch & w_cmp_valid));
    assign w_bht_we       = w_accept & w_is_branch;
    assign w_mispredict   = w_bht_we & (w_cmp_taken != ex_pred_taken);
    assign w_redirect_nxt = (w_accept & ex_jump) | w_mispredict;

    assign w_pc_imm   = ex_pc + ex_imm;
    assign w_pc_seq   = ex_pc + XLEN'(4);
    assign w_jalr_tgt = (ex_rs1 + ex_imm) & ~XLEN'(1);

    always_comb begin
        w_target = w_pc_seq;
        if (ex_jump) begin
            w_target = ex_jalr ? w_jalr_tgt : w_pc_imm;
        end else if (w_cmp_taken) begin
            w_target = w_pc_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= WNT;
            end
        end else if (w_bht_we) begin
            r_bht[w_ex_idx] <= bht_next(w_ex_entry, w_cmp_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect       <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_redirect <= w_redirect_nxt;
            if (w_redirect_nxt) begin
                r_redirect_pc <= w_target;
                if (r_mispredict_cnt != 32'hFFFF_FFFF) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
                end
            end
            if (w_accept && r_branch_cnt != 32'hFFFF_FFFF) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_state <= FL_IDLE;
            r_flush_cnt   <= '0;
        end else begin
            r_flush_state <= w_flush_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
        end
    end

    // The counter holds the number of flush cycles still to be shown, including the current one.
    always_comb begin
        w_flush_state_nxt = r_flush_state;
        w_flush_cnt_nxt   = r_flush_cnt;
        case (r_flush_state)
            FL_IDLE: begin
                w_flush_cnt_nxt = '0;
                if (w_redirect_nxt) begin
                    w_flush_state_nxt = FL_ACTIVE;
                    w_flush_cnt_nxt   = FCW'(FLUSH_CYCLES);
                end
            end
            FL_ACTIVE: begin
                w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
                if (r_flush_cnt <= FCW'(1)) begin
                    w_flush_state_nxt = FL_IDLE;
                    w_flush_cnt_nxt   = '0;
                end
            end
            default: begin
                w_flush_state_nxt = FL_IDLE;
                w_flush_cnt_nxt   = '0;
            end
        endcase
    end

    assign flush          = (r_flush_state == FL_ACTIVE);
    assign redirect       = r_redirect;
    assign redirect_pc    = r_redirect_pc;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a vector table for the condition/target
// logic, then hand sequences for flush squashing, BHT saturation and reset.
module tb_branch_resolve;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_branch, ex_jump, ex_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
    logic        ex_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_cnt, mispredict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve #(
        .XLEN(32), .BHT_DEPTH(16), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    typedef struct {
        logic        valid, branch, jump, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pred;
        logic        expRedirect;
        logic [31:0] expPc, expBcnt, expMcnt;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ex_valid      = v.valid;
        ex_branch     = v.branch;
        ex_jump       = v.jump;
        ex_jalr       = v.jalr;
        ex_funct3     = v.f3;
        ex_rs1        = v.rs1;
        ex_rs2        = v.rs2;
        ex_pc         = v.pc;
        ex_imm        = v.imm;
        ex_pred_taken = v.pred;
    endtask

    task automatic idleInputs();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_jalr = 1'b0;
        ex_funct3 = 3'b000; ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkBr(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        vec_t v;
        v = '{1'b1, 1'b1, 1'b0, 1'b0, f3, rs1, rs2, pc, imm, pred, 1'b0, 32'd0, 32'd0, 32'd0};
        return v;
    endfunction

    function automatic vec_t mkJmp(input logic jalr, input logic [31:0] rs1,
                                   input logic [31:0] pc, input logic [31:0] imm);
        vec_t v;
        v = '{1'b1, 1'b0, 1'b1, jalr, F3_BEQ, rs1, 32'd0, pc, imm, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
        return v;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,F3_BEQ, 32'd5,        32'd5,        32'h100,      32'h40,       1'b0, 1'b1,32'h140,      32'd1, 32'd1};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,F3_BNE, 32'd5,        32'd5,        32'h104,      32'h40,       1'b0, 1'b0,32'h0,        32'd2, 32'd1};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,F3_BNE, 32'd5,        32'd6,        32'h108,      32'h20,       1'b1, 1'b0,32'h0,        32'd3, 32'd1};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,F3_BLT, 32'hFFFF_FFFF,32'd1,        32'h200,      32'h10,       1'b0, 1'b1,32'h210,      32'd4, 32'd2};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,F3_BLTU,32'hFFFF_FFFF,32'd1,        32'h204,      32'h10,       1'b0, 1'b0,32'h0,        32'd5, 32'd2};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,F3_BGE, 32'h8000_0000,32'd0,        32'h300,      32'h8,        1'b1, 1'b1,32'h304,      32'd6, 32'd3};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,F3_BGEU,32'h8000_0000,32'd0,        32'h308,      32'h8,        1'b0, 1'b1,32'h310,      32'd7, 32'd4};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,3'b010, 32'd5,        32'd5,        32'h400,      32'h40,       1'b1, 1'b0,32'h0,        32'd7, 32'd4};
        vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,F3_BEQ, 32'd0,        32'd0,        32'h500,      32'hFFFF_FF00,1'b0, 1'b1,32'h400,      32'd8, 32'd5};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,F3_BEQ, 32'h1001,     32'd0,        32'h504,      32'h2,        1'b0, 1'b1,32'h1002,     32'd9, 32'd6};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b0,F3_BEQ, 32'd5,        32'd6,        32'h600,      32'h80,       1'b0, 1'b1,32'h680,      32'd10,32'd7};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,F3_BEQ, 32'd1,        32'd1,        32'h604,      32'h40,       1'b0, 1'b0,32'h0,        32'd10,32'd7};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b0,F3_BEQ, 32'd0,        32'd0,        32'hFFFF_FFF0,32'h20,       1'b0, 1'b1,32'h10,       32'd11,32'd8};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0,F3_BEQ, 32'd1,        32'd2,        32'hFFFF_FFFC,32'h40,       1'b1, 1'b1,32'h0,        32'd12,32'd9};

        if_pc = '0;
        doReset();
        checkOutput("reset redirect", {31'd0, redirect}, 32'd0);
        checkOutput("reset redirect_pc", redirect_pc, 32'd0);
        checkOutput("reset flush", {31'd0, flush}, 32'd0);
        checkOutput("reset branch_cnt", branch_cnt, 32'd0);
        checkOutput("reset mispredict_cnt", mispredict_cnt, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            checkOutput($sformatf("reset pred idx%0d", i), {31'd0, if_pred_taken}, 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].expRedirect});
            if (vecs[i].expRedirect) begin
                checkOutput($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].expPc);
            end
            checkOutput($sformatf("vec%0d branch_cnt", i), branch_cnt, vecs[i].expBcnt);
            checkOutput($sformatf("vec%0d mispredict_cnt", i), mispredict_cnt, vecs[i].expMcnt);
            checkOutput($sformatf("vec%0d flush c1", i), {31'd0, flush}, {31'd0, vecs[i].expRedirect});
            idleInputs();
            tick();
            checkOutput($sformatf("vec%0d redirect pulse", i), {31'd0, redirect}, 32'd0);
            checkOutput($sformatf("vec%0d flush c2", i), {31'd0, flush}, {31'd0, vecs[i].expRedirect});
            tick();
            checkOutput($sformatf("vec%0d flush c3", i), {31'd0, flush}, 32'd0);
        end

        // BEQ taken, mispredicted; same-cycle IF read sees the old entry
        doReset();
        if_pc = 32'h100;
        applyStimulus(mkBr(F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0));
        #1;
        checkOutput("beq read-old", {31'd0, if_pred_taken}, 32'd0);
        tick();
        checkOutput("beq redirect", {31'd0, redirect}, 32'd1);
        checkOutput("beq redirect_pc", redirect_pc, 32'h140);
        checkOutput("beq mispredict_cnt", mispredict_cnt, 32'd1);
        checkOutput("beq bht WT", {31'd0, if_pred_taken}, 32'd1);
        checkOutput("beq flush1", {31'd0, flush}, 32'd1);
        idleInputs();
        tick();
        checkOutput("beq flush2", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("beq flush3", {31'd0, flush}, 32'd0);

        // JALR, then a BNE during flush that must be squashed
        applyStimulus(mkJmp(1'b1, 32'h1001, 32'h700, 32'h2));
        tick();
        checkOutput("jalr redirect_pc", redirect_pc, 32'h1002);
        checkOutput("jalr branch_cnt", branch_cnt, 32'd2);
        applyStimulus(mkBr(F3_BNE, 32'd5, 32'd6, 32'h704, 32'h40, 1'b0));
        tick();
        checkOutput("squash redirect", {31'd0, redirect}, 32'd0);
        checkOutput("squash branch_cnt", branch_cnt, 32'd2);
        checkOutput("squash mispredict_cnt", mispredict_cnt, 32'd2);
        idleInputs();
        tick();
        if_pc = 32'h704;
        #1;
        checkOutput("squash no bht update", {31'd0, if_pred_taken}, 32'd0);

        // Four taken branches at one PC, then two not-taken
        if_pc = 32'h184;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mkBr(F3_BEQ, 32'd7, 32'd7, 32'h184, 32'h40, (k != 0)));
            tick();
            checkOutput($sformatf("sat%0d redirect", k), {31'd0, redirect}, (k == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("sat%0d pred", k), {31'd0, if_pred_taken}, 32'd1);
            idleInputs();
            tick();
            tick();
        end
        checkOutput("sat branch_cnt", branch_cnt, 32'd6);
        checkOutput("sat mispredict_cnt", mispredict_cnt, 32'd3);
        applyStimulus(mkBr(F3_BEQ, 32'd1, 32'd2, 32'h184, 32'h40, 1'b1));
        tick();
        checkOutput("nt1 redirect", {31'd0, redirect}, 32'd1);
        checkOutput("nt1 redirect_pc", redirect_pc, 32'h188);
        checkOutput("nt1 pred WT", {31'd0, if_pred_taken}, 32'd1);
        idleInputs();
        tick();
        tick();
        applyStimulus(mkBr(F3_BEQ, 32'd1, 32'd2, 32'h184, 32'h40, 1'b1));
        tick();
        checkOutput("nt2 redirect", {31'd0, redirect}, 32'd1);
        checkOutput("nt2 pred WNT", {31'd0, if_pred_taken}, 32'd0);
        checkOutput("nt2 branch_cnt", branch_cnt, 32'd8);
        checkOutput("nt2 mispredict_cnt", mispredict_cnt, 32'd5);
        idleInputs();
        tick();
        tick();

        // Reset asserted in the cycle after a redirect
        applyStimulus(mkJmp(1'b0, 32'd0, 32'h800, 32'h10));
        tick();
        checkOutput("prerst redirect", {31'd0, redirect}, 32'd1);
        rst = 1'b1;
        idleInputs();
        tick();
        checkOutput("rst flush", {31'd0, flush}, 32'd0);
        checkOutput("rst redirect", {31'd0, redirect}, 32'd0);
        checkOutput("rst redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst branch_cnt", branch_cnt, 32'd0);
        checkOutput("rst mispredict_cnt", mispredict_cnt, 32'd0);
        if_pc = 32'h100;
        #1;
        checkOutput("rst bht WNT", {31'd0, if_pred_taken}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("postrst flush", {31'd0, flush}, 32'd0);
        checkOutput("postrst redirect", {31'd0, redirect}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Parametrised branch resolution and prediction unit for the RISC-V pipeline, replacing the single-cycle `zero & Branch` PCSrc gate.
- Evaluates all six RV32I conditional branches plus JAL/JALR on operands of width XLEN.
- Keeps a 2-bit-saturating-counter branch history table (BHT) that is read from IF.
- Resolves in EX and issues a registered redirect and a multi-cycle flush to the front end.
- Exposes branch and mispredict performance counters.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- BHT_DEPTH, 16, BHT entries; power of two, ≥2
- FLUSH_CYCLES, 2, cycles flush stays high per redirect; ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  PC of the instruction being fetched
- if_pred_taken  out  1  BHT prediction for if_pc (combinational)
- ex_valid  in  1  EX holds a live instruction
- ex_branch  in  1  conditional branch
- ex_jump  in  1  JAL or JALR
- ex_jalr  in  1  JALR (qualifies ex_jump)
- ex_funct3  in  3  branch condition
- ex_rs1, ex_rs2  in  XLEN  operands
- ex_pc, ex_imm  in  XLEN  instruction PC, sign-extended immediate
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- redirect  out  1  registered; fetch must load redirect_pc
- redirect_pc  out  XLEN  registered target
- flush  out  1  squash IF/ID
- branch_cnt  out  32  resolved branches+jumps, saturating
- mispredict_cnt  out  32  redirects issued, saturating

## Operation
- BHT index = pc[IDX+1:2], IDX = log2(BHT_DEPTH). Entry ≥ 2'b10 predicts taken.
- if_pred_taken = MSB of BHT[index(if_pc)]. A read and a write to the same entry in one cycle return the old value.
- Conditions by ex_funct3:
  - 000 BEQ, 001 BNE: equality.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010/011: invalid; the instruction is treated as a non-branch (no update, no count).
- Accepted event = ex_valid & (ex_branch | ex_jump) & ~flush & valid funct3. Anything else is ignored entirely.
- Conditional branch, accepted:
  - BHT[index(ex_pc)] saturates +1 if taken, −1 if not taken.
  - branch_cnt increments.
  - Mispredict when taken ≠ ex_pred_taken.
  - Target is ex_pc+ex_imm if taken, else ex_pc+4.
- Jump, accepted:
  - Always redirects; no BHT update.
  - JAL target = ex_pc+ex_imm.
  - JALR target = (ex_rs1+ex_imm) & ~1.
  - branch_cnt increments.
- On a mispredict or jump: redirect and mispredict_cnt increment, and the flush counter loads FLUSH_CYCLES.
- All adds are modulo 2^XLEN; wrap-around is silent.
- Counters hold at 32'hFFFF_FFFF.
- ex_branch & ex_jump both high: ex_jump wins.

## Timing
- Reset values:
  - redirect=0, redirect_pc=0, flush=0.
  - Both counters 0; flush counter 0.
  - Every BHT entry 2'b01 (weakly not-taken).
- if_pred_taken: zero latency from if_pc.
- Resolution latency is 1 cycle. Event in EX at cycle N gives redirect=1 (one cycle pulse) and redirect_pc valid at cycle N+1.
- The BHT write is visible to IF reads from N+1.
- Flush counter:
  - flush=1 for cycles N+1 … N+FLUSH_CYCLES.
  - It decrements each cycle and is held at 0 otherwise.
- EX events during flush are squashed: no redirect, no update, no count. A second redirect cannot occur inside the window.
- rst mid-flush or with a redirect pending: cleared on the next edge; nothing is emitted afterward.

## Structure
- Shared package (`riscv_pkg`) holds:
  - funct3 constants F3_BEQ…F3_BGEU.
  - The 2-bit counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Sub-module `branch_cmp` is natural: combinational, XLEN-parametrised. It takes funct3, rs1, rs2 and outputs taken and a valid flag.
- The BHT array, counters and flush FSM stay in the top module.

## Test plan
- After reset, sweep if_pc over 16 indices → if_pred_taken=0 everywhere.
- BEQ with rs1=rs2=5, pred 0, pc=0x100, imm=0x40:
  - next cycle redirect=1, redirect_pc=0x140.
  - flush high exactly 2 cycles.
  - mispredict_cnt=1; BHT[0] reads WT.
- BLT vs BLTU with rs1=0xFFFF_FFFF, rs2=1, both pred 0:
  - BLT is taken and redirects.
  - BLTU is not taken; no redirect, branch_cnt still increments.
- JALR with rs1=0x1001, imm=2 → redirect_pc=0x1002. A BNE presented in the following flush cycle is ignored (counts unchanged).
- Four consecutive taken branches at one PC, separated by idle cycles:
  - counter saturates at ST.
  - Redirect only on the first one.
  - Then one not-taken branch with pred 1 → redirect_pc=pc+4, entry becomes WT.
- Assert rst in the cycle after a redirect → flush=0 next cycle, counters 0, BHT back to WNT.
